// File: rtl/rvv_vrf_retire_merge.sv
// Retire-to-VRF write merge: folds up to NUM_RT_UOP retiring uops per cycle into
// registered full-width per-register write enables/data, plus retire pulses and a counter.
`ifndef VLEN
`define VLEN 128
`endif
`ifndef NUM_RT_UOP
`define NUM_RT_UOP 4
`endif

module rvv_vrf_retire_merge #(
  parameter int VLEN       = `VLEN,
  parameter int VLENB      = VLEN / 8,
  parameter int NUM_RT_UOP = `NUM_RT_UOP
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_RT_UOP-1:0]               rt_valid,
  output logic [NUM_RT_UOP-1:0]               rt_ready,
  input  logic [NUM_RT_UOP-1:0][4:0]          rt_vd,
  input  logic [NUM_RT_UOP-1:0][VLENB-1:0]    rt_wen,
  input  logic [NUM_RT_UOP-1:0][VLEN-1:0]     rt_data,
  input  logic [NUM_RT_UOP-1:0]               rt_last,
  input  logic                                wr_hold,
  output logic [31:0][VLENB-1:0]              vrf_wr_wen_full,
  output logic [31:0][VLEN-1:0]               vrf_wr_data_full,
  output logic [NUM_RT_UOP-1:0]               rt_uop,
  output logic [NUM_RT_UOP-1:0]               rt_last_uop,
  output logic [31:0]                         retired_insn_cnt,
  output logic                                proto_err
);

  localparam int CNT_W = $clog2(NUM_RT_UOP + 1);

  logic [NUM_RT_UOP-1:0]  eligible;
  logic [NUM_RT_UOP-1:0]  accept;
  logic                   gap_err;
  logic [CNT_W-1:0]       last_cnt;
  logic [31:0][VLENB-1:0] merge_wen;
  logic [31:0][VLEN-1:0]  merge_data;

  // A slot is eligible only while every older slot is also valid.
  always_comb begin : elig_chain
    logic run;
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    run      = 1'b1;
    eligible = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      run         = run & rt_valid[i];
      eligible[i] = run;
    end
  end

  assign rt_ready = eligible & {NUM_RT_UOP{~wr_hold}};
  assign accept   = rt_valid & rt_ready;
  assign gap_err  = |(rt_valid & ~eligible);

  always_comb begin
    last_cnt = '0;
    for (int i = 0; i < NUM_RT_UOP; i++) begin
      last_cnt = last_cnt + CNT_W'(accept[i] & rt_last[i]);
    end
  end

  // Slots are scanned oldest to youngest, so a later hit overwrites an earlier one
  // and the youngest uop owns any byte written by more than one slot.
  always_comb begin
    merge_wen  = '0;
    merge_data = '0;
    for (int r = 0; r < 32; r++) begin
      for (int s = 0; s < NUM_RT_UOP; s++) begin
        if (accept[s] && (rt_vd[s] == 5'(r))) begin
          for (int b = 0; b < VLENB; b++) begin
            if (rt_wen[s][b]) begin
              merge_wen[r][b]          = 1'b1;
              merge_data[r][b*8 +: 8]  = rt_data[s][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data vectors are reset as well; downstream sees zero data, not stale X, out of reset.
      vrf_wr_wen_full  <= '0;
      vrf_wr_data_full <= '0;
      rt_uop           <= '0;
      rt_last_uop      <= '0;
      retired_insn_cnt <= '0;
      proto_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      vrf_wr_wen_full  <= merge_wen;
      vrf_wr_data_full <= merge_data;
      rt_uop           <= accept;
      rt_last_uop      <= accept & rt_last;
      retired_insn_cnt <= retired_insn_cnt + 32'(last_cnt);
      if (gap_err) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
